// File: rtl/t_vga_v1_frame_reader_if.sv
// Avalon-MM read bus and Avalon-ST pixel stream of the VGA frame reader.
`timescale 1ns/1ps
interface t_vga_v1_frame_reader_if #(
    parameter int unsigned ADDR_W = 13
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic [15:0]       aso_data;
    logic              aso_valid;
    logic              aso_ready;
    logic              aso_startofpacket;
    logic              aso_endofpacket;

    modport master (
        output avm_address, avm_read,
        input  avm_waitrequest, avm_readdata,
        output aso_data, aso_valid, aso_startofpacket, aso_endofpacket,
        input  aso_ready
    );

    modport slave (
        input  avm_address, avm_read,
        output avm_waitrequest, avm_readdata,
        input  aso_data, aso_valid, aso_startofpacket, aso_endofpacket,
        output aso_ready
    );
endinterface

// File: rtl/t_vga_v1_frame_reader.sv
// Frame-buffer scanner: Avalon-MM word reads into a prefetch FIFO, unpacked
// into a framed Avalon-ST RGB565 pixel stream (low half of each word first).
`timescale 1ns/1ps
module t_vga_v1_frame_reader #(
    parameter int unsigned FRAME_WORDS = 5120,
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    t_vga_v1_frame_reader_if.master        bus,
    output logic                           busy
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned PIX_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(2 * FRAME_WORDS - 1);
    localparam logic [CNT_W:0]    DEPTH_V   = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              outst_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  left;
    logic              half_q, half_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              valid_q, valid_d;
    logic [15:0]       data_q, data_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              busy_q, busy_d;
    logic [31:0]       head;
    logic [31:0]       mem [FIFO_DEPTH];

    logic accept;
    logic hs;
    logic pop;
    logic push;

    assign accept = rd_q && !bus.avm_waitrequest;
    assign hs     = valid_q && bus.aso_ready;
    assign pop    = hs && half_q;
    assign push   = outst_q;

    // Next-state, read issue and next output-register contents.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rd_d     = 1'b0;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        left     = cnt_q - CNT_W'(pop);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        half_d   = half_q;
        pix_d    = pix_q;
        head     = '0;
        valid_d  = 1'b0;
        data_d   = '0;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        busy_d   = 1'b0;

        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (enable) state_d = FETCH;
            end
            FETCH: begin
                if (accept && addr_q == LAST_ADDR) state_d = DRAIN;
            end
            DRAIN: begin
                // Empty FIFO with nothing in flight means the eop word has been popped.
                if (cnt_q == '0 && !outst_q) state_d = enable ? FETCH : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);

        // A stalled request is held; otherwise issue only if the word will fit.
        if (rd_q && bus.avm_waitrequest) begin
            rd_d = 1'b1;
        end else if (state_d == FETCH) begin
            rd_d = ({1'b0, cnt_d} + (CNT_W + 1)'(accept)) < DEPTH_V;
        end

        if (hs) begin
            half_d = ~half_q;
            pix_d  = eop_q ? '0 : pix_q + PIX_W'(1);
        end

        // Word shown next cycle: the one being written if the FIFO drains to it.
        head    = (left == '0) ? bus.avm_readdata : mem[rd_ptr_d];
        valid_d = (cnt_d != '0);
        if (valid_d) begin
            data_d = half_d ? head[31:16] : head[15:0];
            sop_d  = (pix_d == '0);
            eop_d  = (pix_d == LAST_PIX);
        end

        busy_d = (state_d != IDLE);
    end

    // State and control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            outst_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            half_q   <= 1'b0;
            pix_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            outst_q  <= accept;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            pix_q    <= pix_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            busy_q   <= busy_d;
        end
    end

    // FIFO storage; read data arrives the cycle after its accept.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.avm_readdata;
    end

    assign bus.avm_address       = addr_q;
    assign bus.avm_read          = rd_q;
    assign bus.aso_data          = data_q;
    assign bus.aso_valid         = valid_q;
    assign bus.aso_startofpacket = sop_q;
    assign bus.aso_endofpacket   = eop_q;
    assign busy                  = busy_q;
endmodule

// File: tb/tb_t_vga_v1_frame_reader.sv
// Scoreboard bench for t_vga_v1_frame_reader: RAM model, random stalls,
// enable drop and mid-frame reset.
`timescale 1ns/1ps
module tb_t_vga_v1_frame_reader;
    localparam int unsigned FRAME_WORDS = 5120;
    localparam int NPIX = 2 * FRAME_WORDS;

    typedef struct packed {
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } pix_t;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic busy;

    t_vga_v1_frame_reader_if #(.ADDR_W(13)) bus ();

    t_vga_v1_frame_reader #(
        .FRAME_WORDS(FRAME_WORDS),
        .ADDR_W(13),
        .FIFO_DEPTH(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .bus(bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    pix_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   bp_on = 1'b0;
    bit   wr_on = 1'b0;
    int   pix_seen = 0;
    int   eop_seen = 0;
    int   words_acc = 0;
    int   words_pop = 0;
    int   exp_addr = 0;
    int   eop_cyc = 0;
    int   gap = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM model: word n = {2n+1, 2n}, fixed read latency 1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.avm_readdata <= '0;
        end else if (bus.avm_read && !bus.avm_waitrequest) begin
            bus.avm_readdata <= {16'(2 * int'(bus.avm_address) + 1), 16'(2 * int'(bus.avm_address))};
        end
    end

    // Sink ready and slave stall drivers.
    initial begin
        bus.aso_ready = 1'b1;
        bus.avm_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.aso_ready       = bp_on ? ($urandom_range(0, 9) < 3) : 1'b1;
            bus.avm_waitrequest = wr_on ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: scoreboard pops, address order, hold-stability and issue rule.
    logic        st_pend = 1'b0;
    logic [18:0] st_snap;
    logic        rd_pend = 1'b0;
    logic [13:0] rd_snap;
    always @(negedge clk) begin
        pix_t e;
        if (!reset_n) begin
            st_pend   = 1'b0;
            rd_pend   = 1'b0;
            exp_addr  = 0;
            words_acc = 0;
            words_pop = 0;
            pix_seen  = 0;
        end else begin
            if (st_pend)
                chk("hold_stream", {bus.aso_valid, bus.aso_data, bus.aso_startofpacket, bus.aso_endofpacket}, 32'(st_snap));
            st_pend = bus.aso_valid && !bus.aso_ready;
            st_snap = {bus.aso_valid, bus.aso_data, bus.aso_startofpacket, bus.aso_endofpacket};

            if (rd_pend) chk("hold_read", {bus.avm_read, bus.avm_address}, 32'(rd_snap));
            rd_pend = bus.avm_read && bus.avm_waitrequest;
            rd_snap = {bus.avm_read, bus.avm_address};

            if (bus.avm_read) chk("issue_rule", 32'((words_acc - words_pop) < 8), 32'd1);
            if (bus.avm_read && !bus.avm_waitrequest) begin
                chk("accept_addr", 32'(bus.avm_address), 32'(exp_addr));
                exp_addr = (exp_addr + 1) % FRAME_WORDS;
                words_acc++;
            end

            if (bus.aso_valid && bus.aso_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_pixel: got 0x%0h, expected none (cycle %0d)", bus.aso_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", {bus.aso_data, bus.aso_startofpacket, bus.aso_endofpacket}, 32'(e));
                end
                if (pix_seen % 2 == 1) words_pop++;
                if (bus.aso_startofpacket && eop_seen > 0) gap = cyc - eop_cyc;
                if (bus.aso_endofpacket) begin
                    eop_cyc = cyc;
                    eop_seen++;
                end
                pix_seen++;
            end
        end
    end

    task automatic push_frame();
        for (int i = 0; i < NPIX; i++) exp_q.push_back('{16'(i), i == 0, i == NPIX - 1});
    endtask

    task automatic wait_pix(input int n, input int budget);
        int k = 0;
        while (pix_seen < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_pix", 32'(pix_seen >= n), 32'd1);
    endtask

    task automatic wait_eop(input int n, input int budget);
        int k = 0;
        while (eop_seen < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_eop", 32'(eop_seen >= n), 32'd1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_read",  32'(bus.avm_read), 32'd0);
        chk("rst_addr",  32'(bus.avm_address), 32'd0);
        chk("rst_valid", 32'(bus.aso_valid), 32'd0);
        chk("rst_data",  32'(bus.aso_data), 32'd0);
        chk("rst_sop",   32'(bus.aso_startofpacket), 32'd0);
        chk("rst_eop",   32'(bus.aso_endofpacket), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        repeat (4) @(negedge clk);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_read"}, 32'(bus.avm_read), 32'd0);
        chk({tag, "_valid"}, 32'(bus.aso_valid), 32'd0);
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Two back-to-back frames, enable dropped at pixel 100 of the second.
        #1;
        push_frame();
        push_frame();
        enable = 1'b1;
        @(negedge clk);
        chk("lat_T_read", 32'(bus.avm_read), 32'd0);
        @(negedge clk);
        chk("lat_T1_read", {bus.avm_read, bus.avm_address}, {1'b1, 13'd0});
        @(negedge clk);
        chk("lat_T2_valid", 32'(bus.aso_valid), 32'd0);
        @(negedge clk);
        chk("lat_T3_first", {bus.aso_valid, bus.aso_startofpacket, bus.aso_data}, {1'b1, 1'b1, 16'h0000});
        wait_pix(NPIX + 100, 3 * NPIX);
        chk("frame_gap_le4", 32'(gap <= 4 && gap > 0), 32'd1);
        @(posedge clk);
        #1 enable = 1'b0;
        wait_eop(2, 2 * NPIX);
        chk_idle("idle_a");

        // Random back-pressure and waitrequest, reset at pixel 5000.
        bp_on = 1'b1;
        wr_on = 1'b1;
        @(posedge clk);
        #1;
        push_frame();
        enable = 1'b1;
        wait_pix(pix_seen + 5000, 40000);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        enable  = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk_reset_vals();
        bp_on = 1'b0;
        wr_on = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Restart after reset: must begin at address 0 with sop; single-cycle enable.
        @(posedge clk);
        #1;
        push_frame();
        enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        wait_eop(3, 2 * NPIX);
        chk_idle("idle_c");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/t_vga_v1_frame_reader.md
# t_vga_v1_frame_reader

Avalon-MM read master that scans the on-chip frame-buffer RAM word by word and emits an Avalon-ST 16-bit pixel stream toward the VGA output stage. It sits directly downstream of the 5120 × 32-bit on-chip memory, connected to its s2 slave port. Each 32-bit word holds two RGB565 pixels. An 8-word prefetch FIFO absorbs downstream back-pressure.

## Interface
- FRAME_WORDS, 5120: words per frame; the last word address is FRAME_WORDS-1.
- ADDR_W, 13: width of the word address.
- FIFO_DEPTH, 8: prefetch FIFO depth in 32-bit words; must be a power of 2, at least 4.
- clk  in  1: sole clock.
- reset_n  in  1: asynchronous, active-low reset.
- enable  in  1: level input; while high, frames are read back to back.
- avm_address  out  ADDR_W: word address to the RAM.
- avm_read  out  1: read request.
- avm_waitrequest  in  1: slave stall; tied 0 for on-chip RAM but must be honoured.
- avm_readdata  in  32: read data, valid exactly 1 cycle after an accepted read (fixed latency 1).
- aso_data  out  16: RGB565 pixel.
- aso_valid  out  1: pixel valid.
- aso_ready  in  1: sink ready (readyLatency 0).
- aso_startofpacket  out  1: first pixel of the frame.
- aso_endofpacket  out  1: last pixel of the frame.
- busy  out  1: high in FETCH or DRAIN.

## Operation
- States:
  - IDLE: no reads are issued.
    - enable=1 → FETCH, with the address set to 0.
  - FETCH: issues reads.
    - When the read of address FRAME_WORDS-1 is accepted → DRAIN.
  - DRAIN: waits until the FIFO is empty, no read is outstanding and the eop pixel has been accepted.
    - Then → FETCH at address 0 if enable=1, else → IDLE.
- Read issue rule: avm_read=1 in FETCH only when fifo_count + outstanding < FIFO_DEPTH.
  - outstanding (0 or 1) = a read was accepted in the previous cycle.
  - A read is accepted when avm_read && !avm_waitrequest.
  - avm_address and avm_read are held stable while waitrequest=1.
  - The address increments by 1 on each accept and wraps to 0 after FRAME_WORDS-1.
- Return data: the cycle after an accept, avm_readdata is written into the FIFO unconditionally. Overflow is impossible by the issue rule.
- Unpacking:
  - The FIFO head word presents pixel 0 = bits [15:0] first, then pixel 1 = bits [31:16].
  - A half-select bit toggles on each pixel handshake (aso_valid && aso_ready).
  - The word is popped on the handshake of its upper half.
- Packet framing:
  - A pixel counter (width ADDR_W+1) runs 0..2·FRAME_WORDS-1 and clears on the eop handshake.
  - aso_startofpacket = valid && counter==0.
  - aso_endofpacket = valid && counter==2·FRAME_WORDS-1.
- enable dropping mid-frame: the current frame completes in full, including eop, and the block then goes to IDLE. A frame is never truncated.
- aso_data, sop and eop hold stable while aso_valid=1 and aso_ready=0.

## Timing
- Reset values:
  - avm_read=0, avm_address=0, aso_valid=0, aso_data=0, sop=0, eop=0, busy=0.
  - FIFO empty, state IDLE, half-select=0, pixel counter=0.
- Reset is asynchronous assert. Deassertion is assumed synchronised externally. Reset mid-frame discards everything, and the next frame starts at address 0 with sop.
- enable sampled high in cycle T (IDLE):
  - avm_read=1, address 0 in T+1.
  - With waitrequest=0: data is written to the FIFO at T+2, and aso_valid=1 with sop at T+3 (show-ahead FIFO).
- With aso_ready held high and waitrequest=0, steady state is 1 pixel per cycle. Reads are issued at most every other cycle on average, so the FIFO never underflows after initial fill.
- A simultaneous FIFO push and pop in the same cycle is legal; the count is unchanged.
- Frame-to-frame gap with continuous enable: ≤ 3 cycles between the eop handshake and the next sop.

## Test plan
- Basic frame: RAM model with latency 1, word n = {16'(2n+1), 16'(2n)}, enable=1, aso_ready=1.
  - Required: pixels 0..10239 in order.
  - sop only on pixel 0 (data 0); eop only on pixel 10239 (data 0x27FF).
  - First aso_valid 3 cycles after enable.
- Back-pressure: aso_ready random 30% duty.
  - Required: identical pixel sequence, no drops or duplicates.
  - Data held stable during stalls.
  - avm_read never asserted with fifo_count+outstanding=8.
- Waitrequest: avm_waitrequest random 50%.
  - Required: address and read stable while stalled.
  - Each address 0..5119 accepted exactly once per frame.
- Enable dropped at pixel 100.
  - Required: the frame completes through eop at pixel 10239, then IDLE with busy=0 and avm_read=0.
  - With enable held high instead: the second frame starts at address 0 with sop.
- Reset mid-frame: reset_n low at pixel 5000 for 2 cycles, then enable=1.
  - Required: all outputs are at their reset values during reset.
  - The next pixel out has sop=1, data 0x0000, address 0.
